gf2m_sqr_iter: RTL and testbench



---
 rtl/gf2m_pkg.sv | 32 +++
 rtl/gf2m_sqr_red.sv | 46 ++++
 rtl/gf2m_sqr_iter.sv | 80 ++++++++
 tb/tb_gf2m_sqr_iter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) definitions: NIST binary-field constants, squarer FSM
// states and the bit-interleave helper used by the squarer.
package gf2m_pkg;

  localparam int MAX_M = 571;

  localparam int B163_M = 163;
  localparam logic [162:0] B163_POLY = 163'hC9;

  localparam int B233_M = 233;
  localparam logic [232:0] B233_POLY =
    (233'd1 << 74) | 233'd1;

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    DONE
  } sqr_state_e;

  // Squaring over GF(2) spreads coefficient i to position 2i.
  function automatic logic [2*MAX_M-2:0] sqr_interleave(
    input logic [MAX_M-1:0] v
  );
    logic [2*MAX_M-2:0] s;
    s = '0;
    for (int i = 0; i < MAX_M; i++) begin
      s[2*i] = v[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/gf2m_sqr_red.sv
// Combinational GF(2^M) square followed by full reduction mod
// x^M + POLY. Valid for any M up to gf2m_pkg::MAX_M.
module gf2m_sqr_red
  import gf2m_pkg::*;
#(
  parameter int           M    = B163_M,
  parameter logic [M-1:0] POLY = M'(B163_POLY)
) (
  input  logic [M-1:0] a_i,
  output logic [M-1:0] r_o
);

  logic [MAX_M-1:0]   a_ext;
  logic [2*MAX_M-2:0] sq_full;
  logic [2*M-2:0]     r;

  always_comb begin
    a_ext        = '0;
    a_ext[M-1:0] = a_i;
  end

  assign sq_full = sqr_interleave(a_ext);

  // Clear high terms from the top down; each step cancels x^i with
  // x^(i-M)*F, so the result is fully reduced for any POLY.
  always_comb begin
    r = sq_full[2*M-2:0];
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) begin
        r[i]         = 1'b0;
        r[i-M +: M]  = r[i-M +: M] ^ POLY;
      end
    end
  end

  assign r_o = r[M-1:0];

  logic unused_hi;
  if (M < MAX_M) begin : g_pad
    assign unused_hi =
      ^{sq_full[2*MAX_M-2:2*M-1], r[2*M-2:M]};
  end else begin : g_full
    assign unused_hi = ^r[2*M-2:M];
  end

endmodule

// File: rtl/gf2m_sqr_iter.sv
// Iterative multi-squarer: result = a^(2^k) mod F, one square-and-reduce
// per clock, valid/ready on both sides.
module gf2m_sqr_iter
  import gf2m_pkg::*;
#(
  parameter int           M     = B163_M,
  parameter logic [M-1:0] POLY  = M'(B163_POLY),
  parameter int           CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     a,
  input  logic [CNT_W-1:0] k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     result,
  output logic             busy
);

  sqr_state_e       state_q, state_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     acc_sq;

  gf2m_sqr_red #(
    .M    (M),
    .POLY (POLY)
  ) u_sqr_red (
    .a_i (acc_q),
    .r_o (acc_sq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = a;
          cnt_d   = k;
          state_d = (k == '0) ? DONE : SQR;
        end
      end
      SQR: begin
        acc_d = acc_sq;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = acc_q;

endmodule

// File: tb/tb_gf2m_sqr_iter.sv
// Directed bench for gf2m_sqr_iter: AES-field (M=8) and B-163 instances
// with hand-computed vectors, handshake, backpressure and reset abort.
module tb_gf2m_sqr_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, k8, r8;

  logic         iv163, ir163, ov163, or163, busy163;
  logic [162:0] a163, r163;
  logic [7:0]   k163;

  gf2m_sqr_iter #(
    .M     (8),
    .POLY  (8'h1B),
    .CNT_W (8)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .k         (k8),
    .out_valid (ov8),
    .out_ready (or8),
    .result    (r8),
    .busy      (busy8)
  );

  gf2m_sqr_iter u_dut163 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv163),
    .in_ready  (ir163),
    .a         (a163),
    .k         (k163),
    .out_valid (ov163),
    .out_ready (or163),
    .result    (r163),
    .busy      (busy163)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(
    input string        tag,
    input logic [162:0] got,
    input logic [162:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sel_ov(input bit big);
    return big ? ov163 : ov8;
  endfunction

  function automatic logic [162:0] sel_res(input bit big);
    return big ? r163 : 163'(r8);
  endfunction

  // One operation: offer, optionally poke in_valid while busy, measure
  // latency from the accept edge (counted as cycle 1), then hand off.
  task automatic run_op(
    input bit           big,
    input logic [162:0] av,
    input logic [7:0]   kv,
    input logic [162:0] exp,
    input int           exp_lat,
    input bit           poke,
    input string        tag
  );
    int lat;
    @(negedge clk);
    if (big) begin
      iv163 = 1'b1; a163 = av; k163 = kv;
    end else begin
      iv8 = 1'b1; a8 = av[7:0]; k8 = kv;
    end
    @(posedge clk);
    #1;
    if (big) begin
      iv163 = poke; a163 = ~av; k163 = 8'd3;
      check({tag, "_acc"}, 163'({ir163, busy163}), 163'(2'b01));
    end else begin
      iv8 = poke; a8 = ~av[7:0]; k8 = 8'd3;
      check({tag, "_acc"}, 163'({ir8, busy8}), 163'(2'b01));
    end
    lat = 1;
    while (!sel_ov(big) && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 163'(lat), 163'(exp_lat));
    check({tag, "_res"}, sel_res(big), exp);
    if (big) begin
      iv163 = 1'b0; or163 = 1'b1;
    end else begin
      iv8 = 1'b0; or8 = 1'b1;
    end
    @(posedge clk);
    #1;
    or163 = 1'b0;
    or8   = 1'b0;
    if (big)
      check({tag, "_ret"}, 163'({ir163, ov163}), 163'(2'b10));
    else
      check({tag, "_ret"}, 163'({ir8, ov8}), 163'(2'b10));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; k8 = '0; or8 = 1'b0;
    iv163 = 1'b0; a163 = '0; k163 = '0; or163 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 163'({ir163, ir8}), 163'(2'b11));
    check("rst_valid", 163'({ov163, ov8}), 163'(2'b00));
    check("rst_busy", 163'({busy163, busy8}), 163'(2'b00));
    check("rst_res163", r163, 163'(0));
    check("rst_res8", 163'(r8), 163'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // AES field x^8+x^4+x^3+x+1
    run_op(1'b0, 163'h02, 8'd1, 163'h04, 2, 1'b0, "aes_x");
    run_op(1'b0, 163'h80, 8'd1, 163'h9A, 2, 1'b0, "aes_x7");
    run_op(1'b0, 163'h57, 8'd8, 163'h57, 9, 1'b0, "fermat8");
    run_op(1'b0, 163'h3C, 8'd0, 163'h3C, 1, 1'b1, "k0_poke");
    run_op(1'b0, 163'h02, 8'd3, 163'h1B, 4, 1'b1, "sqr_poke");

    // B-163: x^164 = x^8+x^7+x^4+x
    run_op(1'b1, 163'd1 << 82, 8'd1, 163'h192, 2, 1'b0, "b163_x82");
    run_op(1'b1, 163'd1, 8'd255, 163'd1, 256, 1'b0, "b163_one");
    run_op(1'b1, 163'h5A5, 8'd163, 163'h5A5, 164, 1'b0, "b163_ferm");

    // Backpressure: x -> x^2 -> x^4 held in DONE, then back-to-back op
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h02; k8 = 8'd2;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid", 163'(ov8), 163'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", 163'({ov8, ir8, r8}), 163'({2'b10, 8'h10}));
    end
    iv8 = 1'b1; a8 = 8'h10; k8 = 8'd1; or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
    check("bp_gap", 163'({ir8, ov8}), 163'(2'b10));
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    check("bp_b2b_acc", 163'({ir8, busy8}), 163'(2'b01));
    @(posedge clk);
    #1;
    check("bp_b2b_res", 163'({ov8, r8}), 163'({1'b1, 8'h1B}));
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;

    // Reset abort mid-SQR
    @(negedge clk);
    iv163 = 1'b1; a163 = 163'h5A5; k163 = 8'd100;
    @(posedge clk);
    #1;
    iv163 = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("mid_busy", 163'(busy163), 163'(1));
    rst_n = 1'b0;
    #1;
    check("abort_async",
      163'({ov163, busy163, ir163}), 163'(3'b001));
    check("abort_res", r163, 163'(0));
    @(posedge clk);
    #1;
    check("abort_edge",
      163'({ov163, busy163, ir163}), 163'(3'b001));
    check("abort_res_edge", r163, 163'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 163'd1 << 82, 8'd1, 163'h192, 2, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
